// File: rtl/fifo_feed_ctrl.sv
// ---------------------------------------------------------------------------------------------
// fifo_feed_ctrl
//
// Sequencing controller for the bank of lane FIFOs that feed the CNN systolic array. A tile is
// loaded by distributing the shared input stream round-robin across the lanes (lane pointer
// advances on every accepted word, word counter advances on every lane wrap). The tile is then
// drained with per-lane read enables so that lane i enters the array i cycles after lane 0.
// The controller carries no data: the write data bus is broadcast to every FIFO, and only the
// write/read/enable strobes are generated here.
//
// Build option:
//   FEED_SKEW_EN  defined   -> staggered drain, lane i reads during drain cycles i..i+DEPTH-1,
//                              drain lasts DEPTH+LANES-1 cycles.
//                 undefined -> all lanes read together for DEPTH cycles.
//   The port list is identical in both builds.
//
// Parameters:
//   LANES        number of lane FIFOs (>= 2)
//   DEPTH        words per lane per tile (>= 1, <= FIFO capacity)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   start        begin a tile (sampled only in IDLE)
//   in_valid     upstream word present on the shared data bus
//   in_ready     controller accepts the word this cycle
//   array_stall  freeze the drain (no reads, drain counter held)
//   fifo_full    per-lane full flags
//   fifo_empty   per-lane empty flags
//   fifo_wr      per-lane write strobes (same cycle as the accepted word)
//   fifo_rd      per-lane read strobes
//   fifo_en      FIFO enable, high whenever not IDLE
//   busy         controller is not IDLE
//   done         one-cycle pulse at tile completion (registered)
//   underflow    sticky: a read was issued to an empty lane (registered)
// ---------------------------------------------------------------------------------------------

module fifo_feed_ctrl #(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             array_stall,
    input  logic [LANES-1:0] fifo_full,
    input  logic [LANES-1:0] fifo_empty,
    output logic [LANES-1:0] fifo_wr,
    output logic [LANES-1:0] fifo_rd,
    output logic             fifo_en,
    output logic             busy,
    output logic             done,
    output logic             underflow
);

    // Counter widths
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned WW = (DEPTH > 1) ? $clog2(DEPTH + 1) : 1;
    localparam int unsigned TW = $clog2(DEPTH + LANES);

`ifdef FEED_SKEW_EN
    // Last drain cycle: lane LANES-1 reads its final word at t = DEPTH+LANES-2
    localparam int unsigned TEnd = DEPTH + LANES - 2;
`else
    // All lanes read together, last read at t = DEPTH-1
    localparam int unsigned TEnd = DEPTH - 1;
`endif

    // FSM encoding
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] lane_q,  lane_d;
    logic [WW-1:0] word_q,  word_d;
    logic [TW-1:0] t_q,     t_d;
    logic          done_q,  done_d;
    logic          underflow_q, underflow_d;

    logic          accept;
    logic          last_lane;
    logic          last_word;

    // -----------------------------------------------------------------------------------------
    // Load-side decode
    // -----------------------------------------------------------------------------------------
    assign last_lane = (lane_q == LW'(LANES - 1));
    assign last_word = (word_q == WW'(DEPTH - 1));

    always_comb begin
        in_ready = 1'b0;
        if (state_q == StLoad) begin
            in_ready = ~fifo_full[lane_q];
        end
    end

    assign accept = in_valid & in_ready;

    // Exactly one write strobe, on the lane the pointer currently addresses
    always_comb begin
        fifo_wr = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            fifo_wr[i] = accept & (lane_q == LW'(i));
        end
    end

    // -----------------------------------------------------------------------------------------
    // Drain-side decode
    // -----------------------------------------------------------------------------------------
    always_comb begin
        fifo_rd = '0;
        if ((state_q == StDrain) && !array_stall) begin
            for (int i = 0; i < int'(LANES); i++) begin
`ifdef FEED_SKEW_EN
                // Lane i window is [i, i+DEPTH); this produces the diagonal wavefront
                fifo_rd[i] = (t_q >= TW'(i)) && (t_q < TW'(i + int'(DEPTH)));
`else
                fifo_rd[i] = (t_q < TW'(DEPTH));
`endif
            end
        end
    end

    // -----------------------------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        t_d     = t_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    lane_d  = '0;
                    word_d  = '0;
                end
            end

            StLoad: begin
                if (accept) begin
                    if (last_lane) begin
                        lane_d = '0;
                        word_d = word_q + WW'(1);
                        // Final word of the tile: drain starts on the very next cycle
                        if (last_word) begin
                            state_d = StDrain;
                            t_d     = '0;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end

            StDrain: begin
                if (!array_stall) begin
                    if (t_q == TW'(TEnd)) begin
                        state_d = StDone;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end

            StDone: begin
                // start is not sampled here; a new tile may begin from the next IDLE cycle
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // done is high exactly while the registered state is DONE
    assign done_d      = (state_d == StDone);
    assign underflow_d = underflow_q | (|(fifo_rd & fifo_empty));

    // -----------------------------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            word_q      <= '0;
            t_q         <= '0;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            t_q         <= t_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
        end
    end

    // -----------------------------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------------------------
    assign busy      = (state_q != StIdle);
    assign fifo_en   = busy;
    assign done      = done_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_feed_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_fifo_feed_ctrl
//
// Directed, self-checking bench for fifo_feed_ctrl with LANES=4, DEPTH=8. Expected drain
// patterns follow the FEED_SKEW_EN setting of the build. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled 1 time unit later, well away from the next edge.
// ---------------------------------------------------------------------------------------------

module tb_fifo_feed_ctrl;

    localparam int LANES = 4;
    localparam int DEPTH = 8;
`ifdef FEED_SKEW_EN
    localparam int DL = DEPTH + LANES - 1;
    localparam int FIRST_RD1 = 1;
`else
    localparam int DL = DEPTH;
    localparam int FIRST_RD1 = 0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic             array_stall;
    logic [LANES-1:0] fifo_full;
    logic [LANES-1:0] fifo_empty;
    logic [LANES-1:0] fifo_wr;
    logic [LANES-1:0] fifo_rd;
    logic             fifo_en;
    logic             busy;
    logic             done;
    logic             underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_feed_ctrl #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .array_stall (array_stall),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_wr     (fifo_wr),
        .fifo_rd     (fifo_rd),
        .fifo_en     (fifo_en),
        .busy        (busy),
        .done        (done),
        .underflow   (underflow)
    );

    // Expected read strobes at drain counter value t (unstalled)
    function automatic logic [LANES-1:0] exp_rd(input int t);
        logic [LANES-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef FEED_SKEW_EN
            r[i] = (t >= i) && (t < i + DEPTH);
`else
            r[i] = (t < DEPTH);
`endif
        end
        return r;
    endfunction

    function automatic logic [LANES-1:0] onehot(input int n);
        logic [LANES-1:0] r;
        r = '0;
        r[n % LANES] = 1'b1;
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        start       = 1'b0;
        in_valid    = 1'b0;
        array_stall = 1'b0;
        fifo_full   = '0;
        fifo_empty  = '0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    // Stimulus only: start a tile and push LANES*DEPTH words with no backpressure.
    // Returns positioned in the first drain cycle, before sampling.
    task automatic load_quiet;
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        repeat (LANES * DEPTH) step();
        in_valid = 1'b0;
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_reset;
        idle_inputs();
        start    = 1'b1;
        in_valid = 1'b1;
        reset    = 1'b0;
        #3;
        checks++;
        if ({in_ready, fifo_wr, fifo_rd, fifo_en, busy, done, underflow} !== 15'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0",
                     {in_ready, fifo_wr, fifo_rd, fifo_en, busy, done, underflow});
        end
        step();
        checks++;
        if ({busy, in_ready, fifo_wr} !== 6'b0) begin
            failures++;
            $display("FAIL reset_held_start: got %b required 0", {busy, in_ready, fifo_wr});
        end
        idle_inputs();
        reset = 1'b1;
        step();
        in_valid = 1'b1;
        #1;
        checks++;
        if ({in_ready, fifo_wr, fifo_en, busy, done} !== 8'b0) begin
            failures++;
            $display("FAIL idle_outputs: got %b required 0",
                     {in_ready, fifo_wr, fifo_en, busy, done});
        end
        in_valid = 1'b0;
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_basic;
        int rd_cnt[LANES];
        for (int i = 0; i < LANES; i++) rd_cnt[i] = 0;
        start = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_pre_start_busy: got %b required 0", busy);
        end
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < LANES * DEPTH; n++) begin
            #1;
            checks++;
            if ({in_ready, fifo_en, busy, fifo_wr} !== {3'b111, onehot(n)}) begin
                failures++;
                $display("FAIL basic_load word %0d: got %b required %b", n,
                         {in_ready, fifo_en, busy, fifo_wr}, {3'b111, onehot(n)});
            end
            step();
        end
        in_valid = 1'b1;  // further valid words must not be accepted during drain
        for (int t = 0; t < DL; t++) begin
            #1;
            checks++;
            if ({fifo_rd, fifo_wr, in_ready, done} !== {exp_rd(t), 4'b0, 2'b0}) begin
                failures++;
                $display("FAIL basic_drain t=%0d: got rd=%b wr=%b rdy=%b done=%b required rd=%b",
                         t, fifo_rd, fifo_wr, in_ready, done, exp_rd(t));
            end
            for (int i = 0; i < LANES; i++) rd_cnt[i] += int'(fifo_rd[i]);
            step();
        end
        in_valid = 1'b0;
        start    = 1'b1;  // ignored in DONE
        #1;
        checks++;
        if ({done, busy, fifo_rd} !== {2'b11, 4'b0}) begin
            failures++;
            $display("FAIL basic_done: got done=%b busy=%b rd=%b required done=1 busy=1 rd=0",
                     done, busy, fifo_rd);
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_cnt[i] !== DEPTH) begin
                failures++;
                $display("FAIL basic_read_count lane %0d: got %0d required %0d",
                         i, rd_cnt[i], DEPTH);
            end
        end
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL basic_after_done: got busy=%b done=%b required 0 0", busy, done);
        end
        step();
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            failures++;
            $display("FAIL back_to_back_start: got busy=%b rdy=%b required 1 1", busy, in_ready);
        end
        apply_reset();
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_backpressure;
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < LANES * DEPTH; n++) begin
            if (n == 6 * LANES + 2) begin
                fifo_full = 4'b0100;
                repeat (3) begin
                    #1;
                    checks++;
                    if ({in_ready, fifo_wr, busy} !== 6'b000001) begin
                        failures++;
                        $display("FAIL bp_hold: got rdy=%b wr=%b busy=%b required 0 0000 1",
                                 in_ready, fifo_wr, busy);
                    end
                    step();
                end
                fifo_full = '0;
            end
            // full flag on a lane the pointer is not at must not block
            fifo_full = (n == 5) ? 4'b0001 : 4'b0000;
            start     = (n == 10);
            #1;
            checks++;
            if ({in_ready, fifo_wr} !== {1'b1, onehot(n)}) begin
                failures++;
                $display("FAIL bp_load word %0d: got rdy=%b wr=%b required 1 %b",
                         n, in_ready, fifo_wr, onehot(n));
            end
            step();
        end
        fifo_full = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        #1;
        checks++;
        if (fifo_rd !== exp_rd(0)) begin
            failures++;
            $display("FAIL bp_first_drain: got %b required %b", fifo_rd, exp_rd(0));
        end
        repeat (DL) step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bp_done: got %b required 1", done);
        end
        apply_reset();
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_stall;
        int rd_cnt[LANES];
        int t;
        int stalls_left;
        for (int i = 0; i < LANES; i++) rd_cnt[i] = 0;
        load_quiet();
        t = 0;
        stalls_left = 3;
        while (t < DL) begin
            array_stall = (t == 4) && (stalls_left > 0);
            #1;
            checks++;
            if ({fifo_rd, done} !== {(array_stall ? 4'b0 : exp_rd(t)), 1'b0}) begin
                failures++;
                $display("FAIL stall_drain t=%0d stall=%b: got rd=%b done=%b required rd=%b",
                         t, array_stall, fifo_rd, done, array_stall ? 4'b0 : exp_rd(t));
            end
            for (int i = 0; i < LANES; i++) rd_cnt[i] += int'(fifo_rd[i]);
            if (array_stall) stalls_left--;
            else t++;
            step();
        end
        array_stall = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done: got %b required 1", done);
        end
        for (int i = 0; i < LANES; i++) begin
            checks++;
            if (rd_cnt[i] !== DEPTH) begin
                failures++;
                $display("FAIL stall_read_count lane %0d: got %0d required %0d",
                         i, rd_cnt[i], DEPTH);
            end
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle: got busy=%b required 0", busy);
        end
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_underflow;
        apply_reset();
        load_quiet();
        fifo_empty = 4'b0010;
        for (int t = 0; t < DL; t++) begin
            #1;
            checks++;
            if (underflow !== (t > FIRST_RD1)) begin
                failures++;
                $display("FAIL underflow_drain t=%0d: got %b required %b",
                         t, underflow, (t > FIRST_RD1));
            end
            step();
        end
        fifo_empty = '0;
        step();
        checks++;
        if ({busy, underflow} !== 2'b01) begin
            failures++;
            $display("FAIL underflow_idle: got busy=%b uf=%b required 0 1", busy, underflow);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        checks++;
        if ({busy, underflow} !== 2'b11) begin
            failures++;
            $display("FAIL underflow_after_start: got busy=%b uf=%b required 1 1",
                     busy, underflow);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_reset: got %b required 0", underflow);
        end
        apply_reset();
    endtask

    // -----------------------------------------------------------------------------------------
    task automatic test_reset_mid_drain;
        load_quiet();
        repeat (5) step();
        #1;
        checks++;
        if ({fifo_rd, busy} !== {exp_rd(5), 1'b1}) begin
            failures++;
            $display("FAIL rst_pre: got rd=%b busy=%b required rd=%b busy=1",
                     fifo_rd, busy, exp_rd(5));
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({fifo_rd, fifo_wr, fifo_en, busy, in_ready, done} !== 12'b0) begin
            failures++;
            $display("FAIL rst_async_drop: got rd=%b wr=%b en=%b busy=%b rdy=%b done=%b",
                     fifo_rd, fifo_wr, fifo_en, busy, in_ready, done);
        end
        repeat (3) begin
            step();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_done: got %b required 0", done);
            end
        end
        reset = 1'b1;
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL rst_release: got busy=%b done=%b required 0 0", busy, done);
        end
        start = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (fifo_wr !== 4'b0001) begin
            failures++;
            $display("FAIL rst_fresh_lane0: got %b required 0001", fifo_wr);
        end
        step();
        checks++;
        if (fifo_wr !== 4'b0010) begin
            failures++;
            $display("FAIL rst_fresh_lane1: got %b required 0010", fifo_wr);
        end
        apply_reset();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_stall();
        test_underflow();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_feed_ctrl.md
# fifo_feed_ctrl

Sequencing controller for the bank of `fifo_new` lane FIFOs that feed the CNN systolic array. It loads one tile of operand words into the bank by distributing an incoming stream round-robin across lanes. It then drains the tile with per-lane staggered read enables, so that lane *i* enters the array *i* cycles after lane 0. The controller carries no data: the write data bus is broadcast to every FIFO `dataIn`, and this block drives only the `wr`, `rd` and `en` strobes and observes the `full` and `empty` flags.

## Interface
- `LANES`, 4: number of lane FIFOs (≥2).
- `DEPTH`, 8: words per lane per tile (≥1, ≤ FIFO capacity).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `in_valid`  in  1  upstream word present on the shared data bus.
- `in_ready`  out  1  controller accepts the word this cycle.
- `array_stall`  in  1  freeze the drain (no reads, counter held).
- `fifo_full`  in  LANES  per-lane `full` flags.
- `fifo_empty`  in  LANES  per-lane `empty` flags.
- `fifo_wr`  out  LANES  per-lane write strobe.
- `fifo_rd`  out  LANES  per-lane read strobe.
- `fifo_en`  out  1  FIFO enable; high whenever the controller is not in IDLE.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse at tile completion.
- `underflow`  out  1  sticky error flag: a read was issued to an empty lane.

## Operation
- States: IDLE, LOAD, DRAIN, DONE. Reset puts the FSM in IDLE and clears all counters and `underflow`.
- **IDLE.** Outputs are all 0. If `start`=1, go to LOAD and clear `lane` and `word`.
- **LOAD.**
  - `in_ready` = ~`fifo_full[lane]`.
  - An accept is `in_valid & in_ready`. On an accept, `fifo_wr[lane]`=1 combinationally in the same cycle; no other bit of `fifo_wr` is set.
  - On an accept, `lane` increments and wraps from LANES-1 to 0. `word` increments on each wrap.
  - The accept that writes lane LANES-1 while `word`=DEPTH-1 moves the FSM to DRAIN with `t`=0.
  - `start` is ignored while in this state.
- **DRAIN.**
  - `T_END` = DEPTH+LANES-2.
  - `fifo_rd[i]` = ~`array_stall` & (`t` ≥ i) & (`t` < i+DEPTH).
  - `t` increments only when `array_stall`=0.
  - When `t`=`T_END` and `array_stall`=0, go to DONE.
  - If `fifo_rd[i]`=1 and `fifo_empty[i]`=1, set `underflow`. It stays set until reset; the read strobe is still issued.
- **DONE.** `done`=1 for this one cycle, then go to IDLE. A new `start` is accepted from the next IDLE cycle onward.
- Outputs are combinational decodes of registered state and counters. `done` and `underflow` are registered.
- Counter widths: `lane` is clog2(LANES), `word` is clog2(DEPTH+1), `t` is clog2(DEPTH+LANES).
- Reset mid-operation aborts immediately: strobes drop asynchronously and no `done` is produced. Flushing FIFO contents is the responsibility of the FIFO reset.

## Timing
- `start` high at edge k puts the FSM in LOAD at k. `in_ready` can be high in the cycle following edge k.
- Write latency is 0: the strobe is in the same cycle as the accepted data.
- The first drain cycle immediately follows the final accepted write. No gap or stall is inserted.
- Unstalled drain length: DEPTH+LANES-1 cycles. Lane i reads during drain cycles i…i+DEPTH-1.
- `done` follows the last drain cycle by one cycle.
- Unstalled tile latency: LANES·DEPTH load cycles (no backpressure) + DEPTH+LANES-1 drain cycles + 1 DONE cycle.
- Reset values: `in_ready`, `fifo_wr`, `fifo_rd`, `fifo_en`, `busy`, `done` and `underflow` are all 0.

## Configuration
- `FEED_SKEW_EN` defined:
  - Staggered drain as above.
  - `T_END` = DEPTH+LANES-2.
- `FEED_SKEW_EN` undefined:
  - All lanes read together.
  - `fifo_rd[i]` = ~`array_stall` & (`t` < DEPTH).
  - `T_END` = DEPTH-1, so the drain lasts DEPTH cycles.
- Both configurations have the same port list.

## Test plan
All scenarios use LANES=4, DEPTH=8 with `FEED_SKEW_EN` defined unless stated.
- **Basic tile.** Pulse `start`, then hold `in_valid`=1 for 32 cycles.
  - `fifo_wr` cycles 0001, 0010, 0100, 1000, repeated 8 times.
  - DRAIN: lane0 reads at `t`=0–7 and lane3 at `t`=3–10.
  - `done` pulses once, 12 cycles after the last write.
- **Backpressure.** Hold `fifo_full[2]`=1 during LANES·DEPTH word 6.
  - `in_ready`=0 and no `fifo_wr` strobe while it is held.
  - The lane pointer stays at 2 and the sequence resumes at lane 2 when the flag clears.
- **Stall.** Assert `array_stall` for 3 cycles at `t`=4.
  - `fifo_rd`=0 throughout, and `t` holds at 4.
  - `done` is delayed by exactly 3 cycles. Each lane still receives exactly 8 reads.
- **Underflow.** Force `fifo_empty[1]`=1 during DRAIN.
  - `underflow` rises on the next edge after lane 1's first read.
  - It stays high through IDLE and a new `start`, and clears only on `reset`=0.
- **Reset mid-drain.** Assert `reset`=0 at `t`=5.
  - All strobes go to 0 immediately and `done` never pulses.
  - After release, `start` begins a fresh LOAD at lane 0.
- **No-skew build** (`FEED_SKEW_EN` undefined).
  - All four `fifo_rd` bits are high together for 8 cycles.
  - `done` pulses 9 cycles after the last write.
